// File: rtl/fpga.sv
// Board wrapper for the video-project FPGA: switch-to-LED mirroring, reset indicator and two blink dividers.
// Optional aux-clock activity monitor gating LEDR2 is enabled by defining FPGA_AUX_MONITOR_EN.
module fpga #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int BLINK_PERIOD_US = 1200,
    parameter int AUX_WINDOW      = 256
) (
    input  logic fpga_CLK,
    input  logic fpga_NRST,
    input  logic fpga_CLK_AUX,
    input  logic fpga_SW0,
    input  logic fpga_SW1,
    output logic fpga_LEDR0,
    output logic fpga_LEDR1,
    output logic fpga_LEDR2,
    output logic fpga_LEDR3,
    output logic fpga_SEL_CLK_AUX
);

    localparam int HALF = CLK_FREQ_HZ / 1_000_000 * BLINK_PERIOD_US / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic          en2;

    assign fpga_LEDR0       = fpga_SW0;
    assign fpga_SEL_CLK_AUX = fpga_SW1;
    assign fpga_LEDR3       = fpga_NRST;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            cnt1       <= '0;
            fpga_LEDR1 <= 1'b0;
        end else if (cnt1 == CNT_LAST) begin
            cnt1       <= '0;
            fpga_LEDR1 <= ~fpga_LEDR1;
        end else begin
            cnt1 <= cnt1 + 1'b1;
        end
    end

    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            cnt2       <= '0;
            fpga_LEDR2 <= 1'b0;
        end else if (en2) begin
            if (cnt2 == CNT_LAST) begin
                cnt2       <= '0;
                fpga_LEDR2 <= ~fpga_LEDR2;
            end else begin
                cnt2 <= cnt2 + 1'b1;
            end
        end
    end

`ifdef FPGA_AUX_MONITOR_EN
    localparam int WW = (AUX_WINDOW > 1) ? $clog2(AUX_WINDOW) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(AUX_WINDOW - 1);

    logic [1:0]    aux_sync;
    logic          aux_prev;
    logic          aux_edge;
    logic [WW-1:0] win_cnt;
    logic          win_active;
    logic          aux_ok;

    assign aux_edge = aux_sync[1] ^ aux_prev;

    // The aux clock is only sampled as data; two flops tame metastability before edge detection.
    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            aux_sync <= 2'b00;
            aux_prev <= 1'b0;
        end else begin
            aux_sync <= {aux_sync[0], fpga_CLK_AUX};
            aux_prev <= aux_sync[1];
        end
    end

    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            win_cnt    <= '0;
            win_active <= 1'b0;
            aux_ok     <= 1'b0;
        end else if (win_cnt == WIN_LAST) begin
            // An edge on the last cycle still counts toward the closing window.
            win_cnt    <= '0;
            aux_ok     <= win_active | aux_edge;
            win_active <= 1'b0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (aux_edge) win_active <= 1'b1;
        end
    end

    assign en2 = aux_ok & fpga_SW1;
`else
    localparam int unused_aux_window = AUX_WINDOW;
    logic unused_aux;
    assign unused_aux = fpga_CLK_AUX;
    assign en2        = 1'b1;
`endif

endmodule

// File: tb/tb_fpga.sv
// Directed self-checking bench for fpga; blink period is scaled down via parameters to keep runs short.
`timescale 1ns/1ps
module tb_fpga;

    localparam int CLK_FREQ_HZ     = 50_000_000;
    localparam int BLINK_PERIOD_US = 12;
    localparam int AUX_WINDOW      = 16;
    localparam int HALF            = 300;
    localparam int BUDGET          = 4 * HALF;

    logic fpga_CLK = 1'b0;
    logic fpga_NRST, fpga_CLK_AUX, fpga_SW0, fpga_SW1;
    logic fpga_LEDR0, fpga_LEDR1, fpga_LEDR2, fpga_LEDR3, fpga_SEL_CLK_AUX;
    logic aux_run;

    int n_checks = 0;
    int n_fail   = 0;

    fpga #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .BLINK_PERIOD_US(BLINK_PERIOD_US),
        .AUX_WINDOW     (AUX_WINDOW)
    ) dut (
        .fpga_CLK        (fpga_CLK),
        .fpga_NRST       (fpga_NRST),
        .fpga_CLK_AUX    (fpga_CLK_AUX),
        .fpga_SW0        (fpga_SW0),
        .fpga_SW1        (fpga_SW1),
        .fpga_LEDR0      (fpga_LEDR0),
        .fpga_LEDR1      (fpga_LEDR1),
        .fpga_LEDR2      (fpga_LEDR2),
        .fpga_LEDR3      (fpga_LEDR3),
        .fpga_SEL_CLK_AUX(fpga_SEL_CLK_AUX)
    );

    always #10 fpga_CLK = ~fpga_CLK;

    // Roughly 27 MHz aux source that can be stopped and restarted.
    initial fpga_CLK_AUX = 1'b0;
    always begin
        #18.5;
        if (aux_run) fpga_CLK_AUX = ~fpga_CLK_AUX;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic led(input int which);
        return (which == 1) ? fpga_LEDR1 : fpga_LEDR2;
    endfunction

    // Counts posedges until the chosen LED rises; returns BUDGET if it never does.
    task automatic wait_rise(input int which, output int n, output realtime t);
        logic prev, cur;
        prev = led(which);
        n    = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge fpga_CLK); #1;
            n++;
            cur = led(which);
            if (!prev && cur) break;
            prev = cur;
        end
        t = $realtime;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge fpga_CLK);
        #1;
    endtask

    initial begin
        int      n;
        realtime t0, t1;
        logic    snap;
        int      toggles;

        fpga_NRST = 1'b0; fpga_SW0 = 1'b0; fpga_SW1 = 1'b0; aux_run = 1'b0;

        cycles(10);
        check("rst_ledr3", 32'(fpga_LEDR3), 0);
        check("rst_ledr1", 32'(fpga_LEDR1), 0);
        check("rst_ledr2", 32'(fpga_LEDR2), 0);

        @(negedge fpga_CLK); fpga_NRST = 1'b1;
        wait_rise(1, n, t0);
        check("rel_ledr3", 32'(fpga_LEDR3), 1);
        check("first_rise_ledr1", 32'(n), 32'(HALF));
`ifndef FPGA_AUX_MONITOR_EN
        check("ledr2_in_phase", 32'(fpga_LEDR2), 1);
`endif

        @(negedge fpga_CLK); fpga_SW0 = 1'b1;
        cycles(1);
        check("ledr0_on", 32'(fpga_LEDR0), 1);
        @(negedge fpga_CLK); fpga_SW0 = 1'b0;
        cycles(1);
        check("ledr0_off", 32'(fpga_LEDR0), 0);
        @(negedge fpga_CLK); fpga_SW1 = 1'b1; aux_run = 1'b1;
        cycles(1);
        check("sel_aux_on", 32'(fpga_SEL_CLK_AUX), 1);

        wait_rise(1, n, t0);
        wait_rise(1, n, t1);
        check("ledr1_period_cyc", 32'(n), 32'(2 * HALF));
        check("ledr1_period_time", 32'((t1 - t0) >= 10000.0 && (t1 - t0) <= 14000.0), 1);

        wait_rise(2, n, t0);
        wait_rise(2, n, t1);
        check("ledr2_period_cyc", 32'(n), 32'(2 * HALF));
        check("ledr2_period_time", 32'((t1 - t0) >= 10000.0 && (t1 - t0) <= 14000.0), 1);

        wait_rise(1, n, t0);
        cycles(100);
        check("mid_ledr1_high", 32'(fpga_LEDR1), 1);
        @(negedge fpga_CLK); fpga_NRST = 1'b0;
        #1;
        check("mid_rst_ledr1", 32'(fpga_LEDR1), 0);
        check("mid_rst_ledr2", 32'(fpga_LEDR2), 0);
        check("mid_rst_ledr3", 32'(fpga_LEDR3), 0);
        repeat (5) @(negedge fpga_CLK);
        fpga_NRST = 1'b1;
        wait_rise(1, n, t0);
        check("mid_rel_rise_ledr1", 32'(n), 32'(HALF));
`ifndef FPGA_AUX_MONITOR_EN
        check("mid_rel_ledr2_in_phase", 32'(fpga_LEDR2), 1);
`else
        aux_run = 1'b0;
        cycles(2 * AUX_WINDOW + 4);
        snap    = fpga_LEDR2;
        toggles = 0;
        for (int i = 0; i < 2 * HALF + 10; i++) begin
            cycles(1);
            if (fpga_LEDR2 !== snap) toggles++;
            snap = fpga_LEDR2;
        end
        check("aux_stopped_frozen", 32'(toggles), 0);
        aux_run = 1'b1;
        n = 0;
        snap = fpga_LEDR2;
        for (int i = 0; i < BUDGET; i++) begin
            cycles(1);
            n++;
            if (fpga_LEDR2 !== snap) break;
        end
        check("aux_resume", 32'(n <= 2 * AUX_WINDOW + HALF), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
